// File: rtl/elm_pkg.sv
// elm_pkg: shared ELM output-layer constants and the argmax frame state encoding.
//   SCORE_W   - signed score width produced by the output layer
//   N_CLASSES - number of output classes per frame
//   state_t   - ST_IDLE / ST_COLLECT / ST_DONE
package elm_pkg;
    localparam int SCORE_W = 21;
    localparam int N_CLASSES = 10;
    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DONE} state_t;
endpackage

// File: rtl/argmax_stream_if.sv
// argmax_stream_if: control, score stream and result bundle of argmax_stream.
//   master (producer side): drives start, abort, in_valid, in_data;
//                           sees in_ready, busy, result_valid, index, max_value, margin
//   slave  (argmax_stream): the mirror image
interface argmax_stream_if
    import elm_pkg::*;
#(
    parameter int DATA_WIDTH = SCORE_W,
    parameter int NUM_CLASSES = N_CLASSES
);
    localparam int IDX_WIDTH = $clog2(NUM_CLASSES);
    logic start;
    logic abort;
    logic in_valid;
    logic in_ready;
    logic busy;
    logic result_valid;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic signed [DATA_WIDTH-1:0] max_value;
    logic [IDX_WIDTH-1:0] index;
    logic [DATA_WIDTH:0] margin;
    modport master (
        output start, abort, in_valid, in_data,
        input in_ready, busy, result_valid, index, max_value, margin
    );
    modport slave (
        input start, abort, in_valid, in_data,
        output in_ready, busy, result_valid, index, max_value, margin
    );
endinterface

// File: rtl/argmax_cmp_update.sv
// argmax_cmp_update: combinational top-2 update for one candidate score.
//   cand, cand_idx         - incoming score and its class index
//   best, best_idx, second - current leader, its index, current runner-up
//   next_best, next_best_idx, next_second - updated tracking state
module argmax_cmp_update #(
    parameter int DATA_WIDTH = 21,
    parameter int IDX_WIDTH = 4,
    parameter bit TIE_LAST = 1'b1
) (
    input  logic signed [DATA_WIDTH-1:0] cand,
    input  logic        [IDX_WIDTH-1:0]  cand_idx,
    input  logic signed [DATA_WIDTH-1:0] best,
    input  logic        [IDX_WIDTH-1:0]  best_idx,
    input  logic signed [DATA_WIDTH-1:0] second,
    output logic signed [DATA_WIDTH-1:0] next_best,
    output logic        [IDX_WIDTH-1:0]  next_best_idx,
    output logic signed [DATA_WIDTH-1:0] next_second
);
    logic win;
    assign win = TIE_LAST ? (cand >= best) : (cand > best);
    assign next_best = win ? cand : best;
    assign next_best_idx = win ? cand_idx : best_idx;
    // A dethroned leader becomes runner-up; otherwise the candidate may still
    // displace the runner-up (including an equal non-winning score).
    assign next_second = win ? best : ((cand > second) ? cand : second);
endmodule

// File: rtl/argmax_stream.sv
// argmax_stream: streaming argmax over NUM_CLASSES signed scores per frame.
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - argmax_stream_if.slave: start/abort control, in_valid/in_data/in_ready
//            score stream (beat k = class k), busy, result_valid strobe and the
//            held result index / max_value / margin (winner minus runner-up)
module argmax_stream
    import elm_pkg::*;
#(
    parameter int DATA_WIDTH = SCORE_W,
    parameter int NUM_CLASSES = N_CLASSES,
    parameter bit TIE_LAST = 1'b1
) (
    input logic clock,
    input logic reset,
    argmax_stream_if.slave bus
);
    localparam int IDX_WIDTH = $clog2(NUM_CLASSES);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH:0] LAST_BEAT = (IDX_WIDTH+1)'(NUM_CLASSES - 1);
    state_t state;
    logic [IDX_WIDTH:0] count;
    logic signed [DATA_WIDTH-1:0] best, second, next_best, next_second;
    logic [IDX_WIDTH-1:0] best_idx, next_best_idx;
    assign bus.in_ready = (state == ST_COLLECT);
    assign bus.busy = (state != ST_IDLE);
    argmax_cmp_update #(
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_WIDTH(IDX_WIDTH),
        .TIE_LAST(TIE_LAST)
    ) u_cmp (
        .cand(bus.in_data),
        .cand_idx(count[IDX_WIDTH-1:0]),
        .best(best),
        .best_idx(best_idx),
        .second(second),
        .next_best(next_best),
        .next_best_idx(next_best_idx),
        .next_second(next_second)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            count <= '0;
            best <= '0;
            best_idx <= '0;
            second <= '0;
            bus.result_valid <= 1'b0;
            bus.index <= '0;
            bus.max_value <= '0;
            bus.margin <= '0;
        end else begin
            bus.result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!bus.abort && bus.start) begin
                        state <= ST_COLLECT;
                        count <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (bus.in_valid) begin
                        count <= count + 1'b1;
                        // Beat 0 seeds the tracker so stale state from a previous frame never competes.
                        best <= (count == '0) ? bus.in_data : next_best;
                        best_idx <= (count == '0) ? '0 : next_best_idx;
                        second <= (count == '0) ? MOST_NEG : next_second;
                        if (count == LAST_BEAT) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (!bus.abort) begin
                        bus.result_valid <= 1'b1;
                        bus.index <= best_idx;
                        bus.max_value <= best;
                        // One extra sign bit makes the difference exact and non-negative.
                        bus.margin <= {best[DATA_WIDTH-1], best} - {second[DATA_WIDTH-1], second};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_argmax_stream.sv
// tb_argmax_stream: randomized and directed bench for argmax_stream with a frame-level reference model.
module tb_argmax_stream;
    localparam int W = 21;
    localparam int N = 10;
    localparam int MIN_S = -(1 << (W - 1));
    localparam int MAX_S = (1 << (W - 1)) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    argmax_stream_if #(.DATA_WIDTH(W), .NUM_CLASSES(N)) ifa ();
    argmax_stream_if #(.DATA_WIDTH(W), .NUM_CLASSES(N)) ifb ();
    argmax_stream_if #(.DATA_WIDTH(8), .NUM_CLASSES(2)) ifc ();

    assign ifb.start = ifa.start;
    assign ifb.abort = ifa.abort;
    assign ifb.in_valid = ifa.in_valid;
    assign ifb.in_data = ifa.in_data;

    argmax_stream #(.DATA_WIDTH(W), .NUM_CLASSES(N), .TIE_LAST(1'b1)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
    argmax_stream #(.DATA_WIDTH(W), .NUM_CLASSES(N), .TIE_LAST(1'b0)) dut_b (.clock(clock), .reset(reset), .bus(ifb));
    argmax_stream #(.DATA_WIDTH(8), .NUM_CLASSES(2), .TIE_LAST(1'b1)) dut_c (.clock(clock), .reset(reset), .bus(ifc));

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // Reference: winner is the max (last or first occurrence), runner-up is the
    // largest of the remaining scores, margin is their plain difference.
    function automatic void ref_result(input int s[$], input bit tie_last, output int idx, output int mx, output int mar);
        int sec;
        mx = s[0];
        idx = 0;
        for (int i = 1; i < s.size(); i++)
            if (s[i] > mx || (tie_last && s[i] == mx)) begin
                mx = s[i];
                idx = i;
            end
        sec = MIN_S;
        for (int j = 0; j < s.size(); j++)
            if (j != idx && s[j] > sec) sec = s[j];
        mar = mx - sec;
    endfunction

    // Frame-level model: phase 0 idle, 1 collecting, 2 last beat taken (result pending).
    int phase = 0;
    int q[$];
    bit exp_rv = 0;
    int e_idx[2] = '{0, 0};
    int e_max[2] = '{0, 0};
    int e_mar[2] = '{0, 0};

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase = 0;
            q.delete();
            exp_rv = 0;
            e_idx = '{0, 0};
            e_max = '{0, 0};
            e_mar = '{0, 0};
        end else begin
            exp_rv = 0;
            if (phase == 0) begin
                if (!ifa.abort && ifa.start) begin
                    phase = 1;
                    q.delete();
                end
            end else if (phase == 1) begin
                if (ifa.abort) phase = 0;
                else if (ifa.in_valid) begin
                    q.push_back(int'(ifa.in_data));
                    if (q.size() == N) phase = 2;
                end
            end else begin
                phase = 0;
                if (!ifa.abort) begin
                    exp_rv = 1;
                    for (int t = 0; t < 2; t++) ref_result(q, t[0] == 1'b0, e_idx[t], e_max[t], e_mar[t]);
                end
            end
        end
    end

    // e_*[0] holds the TIE_LAST=1 expectation (dut_a), e_*[1] the TIE_LAST=0 one (dut_b).
    always @(negedge clock) begin
        if (reset) begin
            chk("rv_a", ifa.result_valid, exp_rv);
            chk("rv_b", ifb.result_valid, exp_rv);
            chk("ready_a", ifa.in_ready, phase == 1);
            chk("busy_a", ifa.busy, phase != 0);
            chk("busy_b", ifb.busy, phase != 0);
            chk("idx_a", int'(ifa.index), e_idx[0]);
            chk("max_a", int'(ifa.max_value), e_max[0]);
            chk("margin_a", int'(ifa.margin), e_mar[0]);
            chk("idx_b", int'(ifb.index), e_idx[1]);
            chk("max_b", int'(ifb.max_value), e_max[1]);
            chk("margin_b", int'(ifb.margin), e_mar[1]);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Drives start then the 10 beats; stalls inserts in_valid-low cycles, poke pulses
    // start during them, abort_at >= 0 aborts (with a same-cycle beat) before beat abort_at.
    task automatic frame(input int s[10], input int stalls, input bit poke, input int abort_at);
        int st = stalls;
        ifa.start = 1'b1;
        tick;
        ifa.start = 1'b0;
        for (int i = 0; i < 10;) begin
            if (i == abort_at) begin
                ifa.abort = 1'b1;
                ifa.in_valid = 1'b1;
                ifa.in_data = W'(s[i]);
                tick;
                ifa.abort = 1'b0;
                ifa.in_valid = 1'b0;
                return;
            end
            if (st > 0 && i > 0 && ($urandom_range(0, 2) == 0 || 10 - i <= st)) begin
                ifa.in_valid = 1'b0;
                ifa.in_data = W'($urandom);
                ifa.start = poke;
                st--;
                tick;
                ifa.start = 1'b0;
            end else begin
                ifa.in_valid = 1'b1;
                ifa.in_data = W'(s[i]);
                i++;
                tick;
            end
        end
        ifa.in_valid = 1'b0;
    endtask

    int fr_a[10] = '{5, -3, 12, 7, 0, 12, 1, -8, 2, 11};
    int fr_neg[10] = '{MIN_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S};
    int fr_top[10] = '{MAX_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S, MIN_S};
    int fr_i3[10] = '{1, 2, 3, 40, 4, 5, 6, 7, 8, 9};
    int fr_i7[10] = '{0, 0, 0, 0, 0, 0, 0, 9, 0, 0};
    int fr_r[10];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.in_data = '0;
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data = '0;
        tick;
        chk("reset_rv", ifa.result_valid, 0);
        chk("reset_idx", int'(ifa.index), 0);
        chk("reset_ready", ifa.in_ready, 0);
        chk("reset_busy", ifa.busy, 0);
        tick;
        reset = 1'b1;
        tick;

        // Test 1: ties on 12 at classes 2 and 5.
        frame(fr_a, 0, 0, -1);
        tick;
        chk("t1_rv", ifa.result_valid, 1);
        chk("t1_idx_last", int'(ifa.index), 5);
        chk("t1_max", int'(ifa.max_value), 12);
        chk("t1_margin", int'(ifa.margin), 0);
        chk("t1_idx_first", int'(ifb.index), 2);
        chk("t1_margin_first", int'(ifb.margin), 0);
        tick;
        chk("t1_strobe_once", ifa.result_valid, 0);

        // Test 2: all most-negative, then one maximal class.
        frame(fr_neg, 0, 0, -1);
        tick;
        chk("t2_idx_last", int'(ifa.index), 9);
        chk("t2_idx_first", int'(ifb.index), 0);
        chk("t2_max", int'(ifa.max_value), MIN_S);
        chk("t2_margin", int'(ifa.margin), 0);
        tick;
        frame(fr_top, 0, 0, -1);
        tick;
        chk("t2b_idx", int'(ifa.index), 0);
        chk("t2b_margin", int'(ifa.margin), 2097151);
        chk("t2b_margin_first", int'(ifb.margin), 2097151);
        tick;

        // Test 3: stalls plus start pulses mid-frame; strobe exactly one cycle after DONE.
        frame(fr_a, 3, 1, -1);
        chk("t3_no_early_rv", ifa.result_valid, 0);
        chk("t3_ready_dropped", ifa.in_ready, 0);
        tick;
        chk("t3_rv", ifa.result_valid, 1);
        chk("t3_idx", int'(ifa.index), 5);
        chk("t3_max", int'(ifa.max_value), 12);
        tick;

        // Test 4: abort mid-frame and in DONE keep the previous result.
        frame(fr_i3, 0, 0, -1);
        tick;
        chk("t4_idx3", int'(ifa.index), 3);
        frame(fr_a, 0, 0, 4);
        repeat (3) tick;
        chk("t4_abort_idx", int'(ifa.index), 3);
        chk("t4_abort_busy", ifa.busy, 0);
        frame(fr_a, 0, 0, -1);
        ifa.abort = 1'b1;
        tick;
        ifa.abort = 1'b0;
        chk("t4_done_abort_rv", ifa.result_valid, 0);
        chk("t4_done_abort_idx", int'(ifa.index), 3);
        ifa.abort = 1'b1;
        ifa.start = 1'b1;
        tick;
        ifa.abort = 1'b0;
        ifa.start = 1'b0;
        chk("t4_abort_over_start", ifa.busy, 0);
        frame(fr_i7, 0, 0, -1);
        tick;
        chk("t4_idx7", int'(ifa.index), 7);
        chk("t4_margin9", int'(ifa.margin), 9);
        chk("t4_margin9_first", int'(ifb.margin), 9);
        tick;

        // Test 5: asynchronous reset mid-collect.
        ifa.start = 1'b1;
        tick;
        ifa.start = 1'b0;
        ifa.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifa.in_data = W'(100 + i);
            tick;
        end
        ifa.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("t5_idx", int'(ifa.index), 0);
        chk("t5_max", int'(ifa.max_value), 0);
        chk("t5_margin", int'(ifa.margin), 0);
        chk("t5_ready", ifa.in_ready, 0);
        chk("t5_busy", ifa.busy, 0);
        tick;
        reset = 1'b1;
        tick;
        frame(fr_a, 0, 0, -1);
        tick;
        chk("t5_after_idx", int'(ifa.index), 5);
        chk("t5_after_margin", int'(ifa.margin), 0);
        tick;

        // Randomized frames: narrow ranges force ties, wide ranges exercise extremes.
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 10; k++)
                fr_r[k] = (f % 2 == 0) ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 2097151)) + MIN_S;
            frame(fr_r, int'($urandom_range(0, 4)), f[2], ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1);
            ifa.abort = ($urandom_range(0, 7) == 0);
            tick;
            ifa.abort = 1'b0;
            ifa.in_valid = $urandom_range(0, 1) == 1;
            ifa.in_data = W'($urandom);
            tick;
            ifa.in_valid = 1'b0;
        end

        // Test 6: two classes, 8-bit scores.
        ifc.start = 1'b1;
        tick;
        ifc.start = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data = 8'sh80;
        tick;
        chk("t6_ready_mid", ifc.in_ready, 1);
        ifc.in_data = 8'sh7f;
        tick;
        ifc.in_valid = 1'b0;
        chk("t6_ready_drop", ifc.in_ready, 0);
        tick;
        chk("t6_rv", ifc.result_valid, 1);
        chk("t6_idx", int'(ifc.index), 1);
        chk("t6_max", int'(ifc.max_value), 127);
        chk("t6_margin", int'(ifc.margin), 255);
        tick;
        chk("t6_rv_once", ifc.result_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
